// File: rtl/miriscv_timer_mmio.sv
// Memory-mapped prescaled timer with compare/match on the data-memory bus.
// Optional level interrupt enabled by defining MIRISCV_TIMER_IRQ_EN.
module miriscv_timer_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        irq_o
);

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PRESCALE = 3'd1;
    localparam logic [2:0] REG_COUNT    = 3'd2;
    localparam logic [2:0] REG_COMPARE  = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;

    logic                  ctrl_en;
    logic                  ctrl_ar;
    logic                  ctrl_ie;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pcnt;
    logic [31:0]           count;
    logic [31:0]           compare;
    logic                  match;

    logic        hit;
    logic        wr_hit;
    logic        rd_hit;
    logic [2:0]  sel;
    logic        tick;
    logic        count_wr;
    logic        match_set;
    logic        match_w1c;
    logic [31:0] prescale_ext;
    logic [31:0] prescale_new;
    logic [31:0] rd_val;

    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        return res;
    endfunction

    assign hit       = data_req_i && (data_addr_i[31:5] == BASE_ADDR[31:5]);
    assign wr_hit    = hit && data_we_i;
    assign rd_hit    = hit && !data_we_i;
    assign sel       = data_addr_i[4:2];
    assign tick      = ctrl_en && (pcnt == prescale);
    assign count_wr  = wr_hit && (sel == REG_COUNT) && (|data_be_i);
    // A bus write to COUNT swallows the tick entirely, including its match.
    assign match_set = tick && (count == compare) && !count_wr;
    assign match_w1c = wr_hit && (sel == REG_STATUS) && data_be_i[0] && data_wdata_i[0];

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        prescale_ext = '0;
        prescale_ext[PRESCALE_W-1:0] = prescale;
        prescale_new = be_merge(prescale_ext, data_wdata_i, data_be_i);
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            REG_CTRL:     rd_val[2:0] = {ctrl_ie, ctrl_ar, ctrl_en};
            REG_PRESCALE: rd_val      = prescale_ext;
            REG_COUNT:    rd_val      = count;
            REG_COMPARE:  rd_val      = compare;
            REG_STATUS:   rd_val[0]   = match;
            default:      rd_val      = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_en      <= 1'b0;
            ctrl_ar      <= 1'b0;
            prescale     <= '0;
            pcnt         <= '0;
            count        <= '0;
            compare      <= '0;
            match        <= 1'b0;
            data_rdata_o <= '0;
        end else begin
            data_rdata_o <= rd_hit ? rd_val : '0;

            if (wr_hit && (sel == REG_CTRL) && data_be_i[0]) begin
                ctrl_en <= data_wdata_i[0];
                ctrl_ar <= data_wdata_i[1];
            end
            if (wr_hit && (sel == REG_PRESCALE))
                prescale <= prescale_new[PRESCALE_W-1:0];
            if (wr_hit && (sel == REG_COMPARE))
                compare <= be_merge(compare, data_wdata_i, data_be_i);

            if (wr_hit && ((sel == REG_CTRL) || (sel == REG_PRESCALE)))
                pcnt <= '0;
            else if (ctrl_en)
                pcnt <= tick ? '0 : pcnt + PRESCALE_W'(1);

            if (count_wr)
                count <= be_merge(count, data_wdata_i, data_be_i);
            else if (tick)
                count <= (match_set && ctrl_ar) ? 32'd0 : count + 32'd1;

            if (match_set)
                match <= 1'b1;
            else if (match_w1c)
                match <= 1'b0;
        end
    end

`ifdef MIRISCV_TIMER_IRQ_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_ie <= 1'b0;
            irq_o   <= 1'b0;
        end else begin
            if (wr_hit && (sel == REG_CTRL) && data_be_i[0])
                ctrl_ie <= data_wdata_i[2];
            irq_o <= match && ctrl_ie;
        end
    end
`else
    assign ctrl_ie = 1'b0;
    assign irq_o   = 1'b0;
`endif

endmodule

// File: tb/tb_miriscv_timer_mmio.sv
// Directed self-checking bench for miriscv_timer_mmio; follows the
// MIRISCV_TIMER_IRQ_EN define to decide whether irq_o may assert.
module tb_miriscv_timer_mmio;

    localparam logic [31:0] A_CTRL     = 32'h0000_1000;
    localparam logic [31:0] A_PRESCALE = 32'h0000_1004;
    localparam logic [31:0] A_COUNT    = 32'h0000_1008;
    localparam logic [31:0] A_COMPARE  = 32'h0000_100C;
    localparam logic [31:0] A_STATUS   = 32'h0000_1010;
`ifdef MIRISCV_TIMER_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        irq_o;

    int checks   = 0;
    int failures = 0;

    miriscv_timer_mmio dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_req_i   (data_req_i),
        .data_we_i    (data_we_i),
        .data_be_i    (data_be_i),
        .data_addr_i  (data_addr_i),
        .data_wdata_i (data_wdata_i),
        .data_rdata_o (data_rdata_o),
        .irq_o        (irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Each access occupies exactly one cycle; tasks return 1 time unit after the edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = addr;
        data_wdata_i = data; data_be_i = be;
        @(posedge clk_i); #1;
        data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = addr; data_be_i = 4'h0;
        @(posedge clk_i); #1;
        data_req_i = 1'b0;
        data = data_rdata_o;
    endtask

    task automatic idle_cycle();
        @(posedge clk_i); #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] addrs [5] = '{A_CTRL, A_PRESCALE, A_COUNT, A_COMPARE, A_STATUS};
        bus_write(A_PRESCALE, 32'd2, 4'hF);
        bus_write(A_COUNT, 32'h99, 4'hF);
        bus_write(A_COMPARE, 32'h9A, 4'hF);
        bus_write(A_CTRL, 32'h7, 4'hF);
        repeat (12) idle_cycle();
        bus_read(A_COUNT, rd);
        // Reset with a coinciding write that must be dropped.
        rst_i = 1'b1;
        data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = A_COMPARE;
        data_wdata_i = 32'h55; data_be_i = 4'hF;
        @(posedge clk_i); #1;
        rst_i = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0;
        checks++;
        if (data_rdata_o !== 32'h0) begin
            failures++; $display("FAIL reset_rdata: got %h want 00000000", data_rdata_o);
        end
        checks++;
        if (irq_o !== 1'b0) begin
            failures++; $display("FAIL reset_irq: got %b want 0", irq_o);
        end
        for (int i = 0; i < 5; i++) begin
            bus_read(addrs[i], rd);
            checks++;
            if (rd !== 32'h0) begin
                failures++; $display("FAIL reset_reg[%0d]: got %h want 00000000", i, rd);
            end
        end
    endtask

    task automatic test_byte_enables();
        logic [31:0] rd;
        do_reset();
        bus_write(A_COMPARE, 32'hAABB_CCDD, 4'b0101);
        bus_read(A_COMPARE, rd);
        checks++;
        if (rd !== 32'h00BB_00DD) begin
            failures++; $display("FAIL be_compare: got %h want 00bb00dd", rd);
        end
        bus_write(A_COMPARE, 32'h1122_3344, 4'b0000);
        bus_read(A_COMPARE, rd);
        checks++;
        if (rd !== 32'h00BB_00DD) begin
            failures++; $display("FAIL be_zero_noop: got %h want 00bb00dd", rd);
        end
        bus_write(A_PRESCALE, 32'hFFFF_FFFF, 4'hF);
        bus_read(A_PRESCALE, rd);
        checks++;
        if (rd !== 32'h0000_FFFF) begin
            failures++; $display("FAIL prescale_width: got %h want 0000ffff", rd);
        end
        bus_write(A_PRESCALE, 32'h0000_5A00, 4'b0010);
        bus_read(A_PRESCALE, rd);
        checks++;
        if (rd !== 32'h0000_5AFF) begin
            failures++; $display("FAIL prescale_byte1: got %h want 00005aff", rd);
        end
        bus_write(A_CTRL, 32'hFFFF_FFFE, 4'hF);
        bus_read(A_CTRL, rd);
        checks++;
        if (rd !== (IRQ_ON ? 32'h6 : 32'h2)) begin
            failures++; $display("FAIL ctrl_bits: got %h want %h", rd, IRQ_ON ? 32'h6 : 32'h2);
        end
    endtask

    task automatic test_prescale();
        logic [31:0] rd;
        logic [31:0] exp;
        do_reset();
        bus_write(A_PRESCALE, 32'd3, 4'hF);
        bus_write(A_COMPARE, 32'hFFFF_FFFF, 4'hF);
        bus_write(A_CTRL, 32'h1, 4'hF);          // cycle 0
        for (int c = 1; c <= 10; c++) begin
            bus_read(A_COUNT, rd);
            exp = (c >= 9) ? 32'd2 : (c >= 5) ? 32'd1 : 32'd0;
            checks++;
            if (rd !== exp) begin
                failures++; $display("FAIL prescale_cycle%0d: got %h want %h", c, rd, exp);
            end
        end
        bus_write(A_CTRL, 32'h0, 4'hF);
    endtask

    task automatic test_match_reload();
        logic [31:0] rd;
        logic [31:0] exp;
        do_reset();
        bus_write(A_COMPARE, 32'd4, 4'hF);
        bus_write(A_CTRL, 32'h7, 4'hF);          // cycle 0
        for (int c = 1; c <= 8; c++) begin
            bus_read(A_COUNT, rd);
            exp = (c <= 5) ? 32'(c - 1) : 32'(c - 6);
            checks++;
            if (rd !== exp) begin
                failures++; $display("FAIL reload_cycle%0d: got %h want %h", c, rd, exp);
            end
            checks++;
            if (irq_o !== (IRQ_ON && c >= 6)) begin
                failures++; $display("FAIL irq_cycle%0d: got %b want %b", c + 1, irq_o, IRQ_ON && c >= 6);
            end
        end
        bus_write(A_CTRL, 32'h4, 4'h1);          // stop counting, keep IE
        bus_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h1) begin
            failures++; $display("FAIL match_set: got %h want 00000001", rd);
        end
        bus_write(A_STATUS, 32'h1, 4'h1);
        checks++;
        if (irq_o !== IRQ_ON) begin
            failures++; $display("FAIL irq_lag: got %b want %b", irq_o, IRQ_ON);
        end
        bus_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL match_w1c: got %h want 00000000", rd);
        end
        checks++;
        if (irq_o !== 1'b0) begin
            failures++; $display("FAIL irq_drop: got %b want 0", irq_o);
        end
        bus_read(A_COUNT, rd);
        checks++;
        if (rd !== 32'd4) begin
            failures++; $display("FAIL count_hold: got %h want 00000004", rd);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        do_reset();
        bus_write(A_COMPARE, 32'd5, 4'hF);
        bus_write(A_COUNT, 32'hFFFF_FFFF, 4'hF);
        bus_write(A_CTRL, 32'h1, 4'hF);          // cycle 0
        bus_write(A_CTRL, 32'h0, 4'hF);          // cycle 1 still ticks
        bus_read(A_COUNT, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL wrap_count: got %h want 00000000", rd);
        end
        bus_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL wrap_nomatch: got %h want 00000000", rd);
        end
    endtask

    task automatic test_collisions();
        logic [31:0] rd;
        do_reset();
        bus_write(A_CTRL, 32'h1, 4'hF);          // cycle 0, COMPARE=COUNT=0
        bus_write(A_COUNT, 32'h10, 4'hF);        // cycle 1 would have matched
        bus_write(A_CTRL, 32'h0, 4'hF);          // cycle 2 ticks 0x10 -> 0x11
        bus_read(A_COUNT, rd);
        checks++;
        if (rd !== 32'h11) begin
            failures++; $display("FAIL count_write_wins: got %h want 00000011", rd);
        end
        bus_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL count_write_nomatch: got %h want 00000000", rd);
        end

        do_reset();
        bus_write(A_PRESCALE, 32'd1, 4'hF);
        bus_write(A_CTRL, 32'h3, 4'hF);          // cycle 0; ticks on cycles 2, 4
        repeat (3) idle_cycle();
        bus_write(A_STATUS, 32'h1, 4'h1);        // cycle 4 coincides with a match
        bus_write(A_CTRL, 32'h0, 4'hF);
        bus_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h1) begin
            failures++; $display("FAIL set_beats_w1c: got %h want 00000001", rd);
        end
        bus_write(A_STATUS, 32'h1, 4'h2);
        bus_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h1) begin
            failures++; $display("FAIL w1c_needs_be0: got %h want 00000001", rd);
        end
        bus_write(A_STATUS, 32'h1, 4'h1);
        bus_read(A_STATUS, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL w1c_clear: got %h want 00000000", rd);
        end
    endtask

    task automatic test_decode();
        logic [31:0] rd;
        do_reset();
        bus_write(A_COUNT, 32'h1234, 4'hF);
        bus_write(32'h0000_101C, 32'hFFFF_FFFF, 4'hF);
        checks++;
        if (data_rdata_o !== 32'h0) begin
            failures++; $display("FAIL rdata_after_write: got %h want 00000000", data_rdata_o);
        end
        bus_read(32'h0000_1014, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL unmapped_1014: got %h want 00000000", rd);
        end
        bus_read(32'h0000_101C, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL unmapped_101c: got %h want 00000000", rd);
        end
        bus_write(32'h0000_2008, 32'hDEAD, 4'hF);
        bus_read(32'h0000_100B, rd);             // low address bits ignored
        checks++;
        if (rd !== 32'h1234) begin
            failures++; $display("FAIL outside_write: got %h want 00001234", rd);
        end
        bus_read(32'h0000_2008, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL outside_read: got %h want 00000000", rd);
        end
    endtask

    initial begin
        rst_i = 1'b1; data_req_i = 1'b0; data_we_i = 1'b0;
        data_be_i = 4'h0; data_addr_i = '0; data_wdata_i = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        test_reset();
        test_byte_enables();
        test_prescale();
        test_match_reload();
        test_wrap();
        test_collisions();
        test_decode();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/miriscv_timer_mmio.md
# miriscv_timer_mmio

Memory-mapped timer peripheral that responds on the core's data-memory bus (req / we / byte-enable / addr / wdata / rdata) as a responder alongside the data RAM. It decodes a 32-byte register window at a parameterised base address, exposes a prescaled 32-bit up-counter with a compare register, a sticky match flag and an optional level interrupt. Instantiated in the top level next to the RAM; the top-level data mux selects its `data_rdata_o` for addresses inside its window.

## Interface
- `BASE_ADDR`, default 32'h0000_1000: window base; must be 32-byte aligned.
- `PRESCALE_W`, default 16: width of PRESCALE register, 1..32.
- `clk_i` in 1: single clock, all state on rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `data_req_i` in 1: bus request, valid for one cycle per access.
- `data_we_i` in 1: 1 = write, 0 = read.
- `data_be_i` in 4: byte enables for writes; bit n covers wdata[8n+7:8n].
- `data_addr_i` in 32: byte address.
- `data_wdata_i` in 32: write data.
- `data_rdata_o` out 32: registered read data.
- `irq_o` out 1: level interrupt (see Configuration).

## Operation
- Hit = `data_req_i` && `data_addr_i[31:5] == BASE_ADDR[31:5]`. `addr[4:2]` selects register; `addr[1:0]` ignored. Non-hit requests: no state change.
- Registers (offset: name, reset 0):
  - 0x00 CTRL: [0] EN, [1] AUTORELOAD, [2] IE; other bits read 0.
  - 0x04 PRESCALE: [PRESCALE_W-1:0]; upper bits read 0.
  - 0x08 COUNT: 32-bit counter, R/W.
  - 0x0C COMPARE: 32-bit, R/W.
  - 0x10 STATUS: [0] MATCH, write-1-to-clear (honours `be[0]`).
  - 0x14–0x1C: unmapped; read 0, writes ignored.
- Writes merge per byte: only bytes with `be` set change; `be=0000` write is a no-op.
- Prescaler: internal counter `pcnt` (PRESCALE_W bits). While EN=1: if `pcnt == PRESCALE` then `pcnt<=0` and tick, else `pcnt<=pcnt+1`. EN=0: `pcnt` holds, no ticks. Any write hit to CTRL or PRESCALE clears `pcnt` to 0.
- On tick: if COUNT == COMPARE then MATCH<=1 and COUNT <= AUTORELOAD ? 0 : COUNT+1; else COUNT <= COUNT+1. 0xFFFF_FFFF wraps to 0 without setting MATCH (unless it equals COMPARE).
- Simultaneous events: bus write to COUNT beats tick increment (written value wins, no MATCH from that tick); MATCH set beats W1C in the same cycle.
- Reads return register value as of the request cycle (before that cycle's updates).

## Timing
- Reset (`rst_i`=1 at edge): all registers, `pcnt`, `data_rdata_o`, `irq_o` = 0 the following cycle; a request coinciding with reset is dropped. Reset mid-count aborts immediately.
- Writes take effect at the edge ending the request cycle.
- Read latency 1: `data_rdata_o` valid the cycle after a read hit. In any cycle following a non-read or non-hit cycle `data_rdata_o` = 0.
- No stall/backpressure: every request completes; back-to-back requests every cycle supported.
- CTRL write EN=1 in cycle 0, PRESCALE=P: first tick in cycle 1+P, new COUNT visible cycle 2+P; subsequent ticks every P+1 cycles. P=0 ticks every cycle.
- `irq_o` is a registered-state function: asserts the cycle after MATCH becomes 1 with IE=1; drops the cycle after MATCH clear or IE clear.

## Configuration
- `MIRISCV_TIMER_IRQ_EN` defined: CTRL.IE implemented, `irq_o = MATCH & IE`.
- Not defined: CTRL[2] not stored, reads 0; `irq_o` tied 0; MATCH still functional and pollable.

## Test plan
- Reset: drive writes, assert `rst_i` 1 cycle -> every register reads 0, `data_rdata_o`=0, `irq_o`=0.
- Byte enables: write 0xAABBCCDD to COMPARE (0x100C) with be=0101 after reset -> read returns 0x00BB00DD one cycle after read request.
- Prescale: PRESCALE=3, COMPARE=0xFFFF_FFFF, CTRL=1 in cycle 0 -> COUNT reads 1 from cycle 5, 2 from cycle 9.
- Match/reload: PRESCALE=0, COMPARE=4, CTRL=0b111 -> COUNT sequence 1,2,3,4,0,1…; MATCH=1 and `irq_o`=1 (IRQ_EN build) after the 4→0 step; W1C to STATUS clears `irq_o` next cycle.
- Collisions: write COUNT=0x10 in a tick cycle -> COUNT=0x10, no MATCH; W1C in the same cycle as a match -> MATCH stays 1.
- Decode: read 0x1014 -> 0; write/read 0x2008 (outside window) -> timer state unchanged, `data_rdata_o`=0.
